// File: rtl/strobe_sched_pkg.sv
// Shared definitions for the strobe counter scheduler.
// Provides the channel-index width helper used by the top level and the arbiter.
// Ports: none (package).
package strobe_sched_pkg;

   // Channel index width: a 2-channel block still needs one index bit.
   function automatic int ch_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr_i.
// Ports: req_i request vector, ptr_i highest-priority index, gnt_o one-hot grant,
//        gnt_idx_o granted index, gnt_vld_o any grant made.
module rr_arbiter
   import strobe_sched_pkg::*;
#(
   parameter  int CHANNELS = 4,
   localparam int CH_W     = ch_width(CHANNELS)
) (
   input  logic [CHANNELS-1:0] req_i,
   input  logic [CH_W-1:0]     ptr_i,
   output logic [CHANNELS-1:0] gnt_o,
   output logic [CH_W-1:0]     gnt_idx_o,
   output logic                gnt_vld_o
);

   logic [CH_W-1:0] idx;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      gnt_vld_o = 1'b0;
      idx       = '0;
      // Scan CHANNELS positions starting at the pointer, wrapping around.
      for (int k = 0; k < CHANNELS; k++) begin
         idx = CH_W'((int'(ptr_i) + k) % CHANNELS);
         if (!gnt_vld_o && req_i[idx]) begin
            gnt_vld_o  = 1'b1;
            gnt_o[idx] = 1'b1;
            gnt_idx_o  = idx;
         end
      end
   end

endmodule

// File: rtl/strobe_counter_scheduler.sv
// Shares one pipelined increment/compare datapath among CHANNELS strobe counters.
// Ports: clk/rst (sync, active-high); tick_req per-channel ticks; cfg_valid/cfg_ready/
//        cfg_ch/cfg_value terminal-count writes; strobe terminal pulses; overrun sticky
//        lost-tick flags; busy = any pending or in-flight work.
module strobe_counter_scheduler
   import strobe_sched_pkg::*;
#(
   parameter  int CHANNELS = 4,
   parameter  int WIDTH    = 16,
   parameter  int LATENCY  = 2,
   localparam int CH_W     = ch_width(CHANNELS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] tick_req,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [WIDTH-1:0]    cfg_value,
   output logic [CHANNELS-1:0] strobe,
   output logic [CHANNELS-1:0] overrun,
   output logic                busy
);

   typedef struct packed {
      logic             valid;
      logic [CH_W-1:0]  ch;
      logic [WIDTH-1:0] count;
      logic [WIDTH-1:0] terminal;
   } op_t;

   logic [WIDTH-1:0]    count_q    [CHANNELS];
   logic [WIDTH-1:0]    count_d    [CHANNELS];
   logic [WIDTH-1:0]    terminal_q [CHANNELS];
   logic [WIDTH-1:0]    terminal_d [CHANNELS];
   logic [CHANNELS-1:0] pending_q, pending_d;
   logic [CHANNELS-1:0] inflight_q, inflight_d;
   logic [CHANNELS-1:0] overrun_q, overrun_d;
   logic [CH_W-1:0]     ptr_q, ptr_d;

   // Stage 0 is the newest op; stage LATENCY-1 is the one writing back.
   op_t [LATENCY-1:0]   pipe_q;
   op_t [LATENCY:0]     pipe_ext;
   op_t                 issue_op;
   op_t                 wb;

   logic                cfg_acc;
   logic [CHANNELS-1:0] cfg_mask;
   logic [CHANNELS-1:0] req;
   logic [CHANNELS-1:0] gnt_oh;
   logic [CH_W-1:0]     gnt_idx;
   logic                gnt_vld;
   logic [WIDTH-1:0]    wb_next;
   logic                wb_hit;

   assign cfg_ready = (int'(cfg_ch) < CHANNELS) && !inflight_q[cfg_ch];
   assign cfg_acc   = cfg_valid && cfg_ready;
   assign cfg_mask  = cfg_acc ? (CHANNELS'(1) << cfg_ch) : '0;

   // A channel being reconfigured is held out of arbitration for that cycle.
   assign req = pending_q & ~inflight_q & ~cfg_mask;

   rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
      .req_i     (req),
      .ptr_i     (ptr_q),
      .gnt_o     (gnt_oh),
      .gnt_idx_o (gnt_idx),
      .gnt_vld_o (gnt_vld)
   );

   always_comb begin
      issue_op.valid    = gnt_vld;
      issue_op.ch       = gnt_idx;
      issue_op.count    = count_q[gnt_idx];
      issue_op.terminal = terminal_q[gnt_idx];
   end

   assign pipe_ext = {pipe_q, issue_op};
   assign wb       = pipe_q[LATENCY-1];
   assign wb_next  = wb.count + WIDTH'(1);
   assign wb_hit   = wb.valid && (wb.terminal != '0) && (wb_next == wb.terminal);

   // Gated by rst so an op retiring during the reset cycle never pulses.
   assign strobe  = (wb_hit && !rst) ? (CHANNELS'(1) << wb.ch) : '0;
   assign overrun = overrun_q;
   assign busy    = (|pending_q) || (|inflight_q);

   always_comb begin
      count_d    = count_q;
      terminal_d = terminal_q;
      inflight_d = inflight_q;
      ptr_d      = ptr_q;

      // Write-back; a disabled channel (terminal 0) just consumes the tick.
      if (wb.valid) begin
         count_d[wb.ch]    = ((wb.terminal == '0) || (wb_next == wb.terminal)) ? '0 : wb_next;
         inflight_d[wb.ch] = 1'b0;
      end

      if (gnt_vld) begin
         inflight_d[gnt_idx] = 1'b1;
         ptr_d = (int'(gnt_idx) == CHANNELS - 1) ? '0 : gnt_idx + CH_W'(1);
      end

      // A tick on the channel granted this cycle refills pending rather than overrunning.
      pending_d = (pending_q & ~gnt_oh) | tick_req;
      overrun_d = overrun_q | (tick_req & pending_q & ~gnt_oh);

      if (cfg_acc) begin
         terminal_d[cfg_ch] = cfg_value;
         count_d[cfg_ch]    = '0;
         pending_d[cfg_ch]  = tick_req[cfg_ch];
         overrun_d[cfg_ch]  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q    <= '{default: '0};
         terminal_q <= '{default: '0};
         pending_q  <= '0;
         inflight_q <= '0;
         overrun_q  <= '0;
         ptr_q      <= '0;
         pipe_q     <= '0;
      end else begin
         count_q    <= count_d;
         terminal_q <= terminal_d;
         pending_q  <= pending_d;
         inflight_q <= inflight_d;
         overrun_q  <= overrun_d;
         ptr_q      <= ptr_d;
         pipe_q     <= pipe_ext[LATENCY-1:0];
      end
   end

endmodule

// File: tb/tb_strobe_counter_scheduler.sv
// Directed bench for strobe_counter_scheduler (CHANNELS=4, WIDTH=8, LATENCY=2).
// Expected strobe pulses are queued with their cycle as ticks are driven and
// compared by a negedge monitor; other outputs are checked at directed points.
module tb_strobe_counter_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] tick_req;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [1:0] cfg_ch;
   logic [7:0] cfg_value;
   logic [3:0] strobe;
   logic [3:0] overrun;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit mon_en = 1'b0;
   int t;

   typedef struct {
      int cyc;
      int ch;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   strobe_counter_scheduler #(.CHANNELS(4), .WIDTH(8), .LATENCY(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .tick_req  (tick_req),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_value (cfg_value),
      .strobe    (strobe),
      .overrun   (overrun),
      .busy      (busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   task automatic expect_strobe(input int at, input int ch);
      exp_t e;
      e.cyc = at;
      e.ch  = ch;
      exp_q.push_back(e);
   endtask

   task automatic mon_check();
      logic [3:0] e = 4'b0000;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         e = 4'b0001 << exp_q[0].ch;
         void'(exp_q.pop_front());
      end
      if (strobe !== 4'b0000 || e != 4'b0000) begin
         checks++;
         assert (strobe === e) else begin
            errors++;
            $error("FAIL strobe: observed %b expected %b (cycle %0d)", strobe, e, cyc);
         end
      end
   endtask

   always @(negedge clk) if (mon_en) mon_check();

   task automatic tick(input logic [3:0] m);
      tick_req = m;
      step();
      tick_req = 4'b0000;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic cfg(input int ch, input int val);
      int n = 0;
      cfg_valid = 1'b1;
      cfg_ch    = 2'(ch);
      cfg_value = 8'(val);
      #1;
      while (cfg_ready !== 1'b1 && n < 20) begin
         step();
         #1;
         n++;
      end
      checks++;
      assert (cfg_ready === 1'b1) else begin
         errors++;
         $error("FAIL cfg_accept ch%0d: observed ready %b expected 1", ch, cfg_ready);
      end
      step();
      cfg_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      tick_req  = 4'b0000;
      cfg_valid = 1'b0;
      cfg_ch    = 2'd0;
      cfg_value = 8'd0;
      steps(2);
      rst    = 1'b0;
      mon_en = 1'b1;

      // Reset state
      chk("rst_strobe", strobe, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cfg_ready", cfg_ready, 1);

      // Single channel, terminal 3: strobe after 3rd and 6th ticks
      cfg(1, 3);
      for (int i = 0; i < 6; i++) begin
         if (i == 2 || i == 5) expect_strobe(cyc + 3, 1);
         tick(4'b0010);
         chk("t1_busy_after_tick", busy, 1);
         steps(3);
      end
      steps(4);
      chk("t1_busy_idle", busy, 0);
      chk("t1_overrun", overrun, 0);

      // All channels ticked at once: round-robin from channel 0
      do_reset();
      for (int c = 0; c < 4; c++) cfg(c, 1);
      t = cyc;
      for (int c = 0; c < 4; c++) expect_strobe(t + 3 + c, c);
      tick(4'b1111);
      steps(5);
      chk("t2_busy_t6", busy, 1);
      step();
      chk("t2_busy_t7", busy, 0);
      chk("t2_overrun", overrun, 0);

      // Overrun: tick in grant cycle is fine, tick while in flight is lost
      do_reset();
      cfg(2, 5);
      tick_req = 4'b0100;
      step();
      chk("t3_ovr_t1", overrun, 0);
      step();
      chk("t3_ovr_grant_cycle", overrun, 0);
      step();
      tick_req = 4'b0000;
      chk("t3_ovr_set", overrun, 4'b0100);
      steps(6);
      chk("t3_ovr_sticky", overrun, 4'b0100);
      chk("t3_busy_idle", busy, 0);
      cfg(2, 5);
      chk("t3_ovr_cleared_by_cfg", overrun, 0);

      // Disabled channel (terminal 0) consumes ticks silently
      do_reset();
      cfg(3, 0);
      for (int i = 0; i < 10; i++) begin
         tick(4'b1000);
         steps(3);
      end
      steps(4);
      chk("t4_busy_idle", busy, 0);
      chk("t4_overrun", overrun, 0);

      // Config blocked while in flight; in-flight strobe still fires
      do_reset();
      cfg(0, 2);
      tick(4'b0001);
      steps(4);
      t = cyc;
      expect_strobe(t + 3, 0);
      tick_req = 4'b0001;
      step();
      step();
      cfg_valid = 1'b1;
      cfg_ch    = 2'd0;
      cfg_value = 8'd7;
      #1;
      chk("t5_ready_inflight", cfg_ready, 0);
      step();
      tick_req = 4'b0000;
      chk("t5_ready_writeback", cfg_ready, 0);
      chk("t5_overrun_set", overrun, 4'b0001);
      step();
      chk("t5_ready_retired", cfg_ready, 1);
      step();
      cfg_valid = 1'b0;
      chk("t5_overrun_cleared", overrun, 0);
      chk("t5_busy_cleared", busy, 0);
      for (int i = 0; i < 7; i++) begin
         if (i == 6) expect_strobe(cyc + 3, 0);
         tick(4'b0001);
         steps(3);
      end
      steps(4);
      chk("t5_busy_idle", busy, 0);

      // Reset while a terminal op is in flight
      do_reset();
      cfg(1, 1);
      tick(4'b0010);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t6_strobe", strobe, 0);
      chk("t6_busy", busy, 0);
      chk("t6_overrun", overrun, 0);
      tick(4'b0010);
      steps(5);
      chk("t6_busy_disabled", busy, 0);
      cfg(1, 1);
      expect_strobe(cyc + 3, 1);
      tick(4'b0010);
      steps(5);

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
